// File: rtl/ws2812_bit_serializer.sv
// ws2812_bit_serializer
//   Takes 8-bit RGB332 pixel writes from the string controller and drives a
//   single-wire WS2812-style LED string. A small FIFO sits between the pixel
//   source and the line timing. Each colour is expanded to 24-bit GRB and sent
//   MSB first. Every bit starts high: the high time is short for a '0' and long
//   for a '1'. A frame ends with a long low latch period.
//
// Ports
//   wb_clk_i    : clock
//   wb_rst_i    : asynchronous active-high reset
//   pix_valid   : colour write request
//   pix_color   : RGB332 colour, R=[7:5] G=[4:2] B=[1:0]
//   pix_last    : marks the final pixel of a frame
//   pix_ready   : FIFO can accept an entry (not full)
//   sout        : serial LED line, registered
//   busy        : FSM not idle, or FIFO holds entries
//   frame_done  : one-cycle pulse at the end of the latch period
//   underrun    : one-cycle pulse when a mid-frame pixel boundary finds the FIFO empty
module ws2812_bit_serializer #(
  parameter int TBIT   = 50,
  parameter int T0H    = 16,
  parameter int T1H    = 32,
  parameter int TRESET = 2000,
  parameter int FASIZE = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       pix_valid,
  input  logic [7:0] pix_color,
  input  logic       pix_last,
  output logic       pix_ready,
  output logic       sout,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int DEPTH = 2 ** FASIZE;
  localparam int CYC_W = $clog2(TBIT);
  localparam int LAT_W = $clog2(TRESET + 1);

  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TBIT - 1);
  localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);
  localparam logic [CYC_W-1:0]  HIGH_ONE  = CYC_W'(T1H);
  localparam logic [CYC_W-1:0]  HIGH_ZERO = CYC_W'(T0H);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(TRESET - 1);
  localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
  localparam logic [FASIZE:0]   PTR_ONE   = (FASIZE + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIT   = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // RGB332 -> GRB888: replicate each field's bits so full-scale maps to 0xFF.
  function automatic logic [23:0] expand_rgb332(input logic [7:0] c);
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    r8 = {c[7:5], c[7:5], c[7:6]};
    g8 = {c[4:2], c[4:2], c[4:3]};
    b8 = {c[1:0], c[1:0], c[1:0], c[1:0]};
    return {g8, r8, b8};
  endfunction

  // FIFO storage; pointers carry one extra wrap bit to tell full from empty.
  logic [8:0]        fifo_mem_q [DEPTH];
  logic [FASIZE:0]   wr_ptr_q;
  logic [FASIZE:0]   rd_ptr_q;

  // Serializer state
  state_t            state_q;
  logic [23:0]       shift_q;
  logic              last_q;
  logic [4:0]        bit_cnt_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [LAT_W-1:0]  lat_q;
  logic              sout_q;
  logic              frame_done_q;
  logic              underrun_q;

  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              push_s;
  logic              pop_s;
  logic [8:0]        head_s;
  logic              word_end_s;
  logic              high_s;

  // FIFO status, pop decision and the high/low phase of the current bit.
  always_comb begin
    fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    fifo_full_s  = (wr_ptr_q[FASIZE] != rd_ptr_q[FASIZE]) &&
                   (wr_ptr_q[FASIZE-1:0] == rd_ptr_q[FASIZE-1:0]);
    head_s       = fifo_mem_q[rd_ptr_q[FASIZE-1:0]];
    push_s       = pix_valid && !fifo_full_s;
    word_end_s   = (state_q == ST_BIT) && (cyc_q == CYC_LAST) && (bit_cnt_q == 5'd0);
    pop_s        = 1'b0;
    if (fifo_empty_s) begin
      pop_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      pop_s = 1'b1;
    end else if (word_end_s && !last_q) begin
      // Reload at the last cycle of the final bit so the next pixel has no gap.
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (shift_q[23]) begin
      high_s = (cyc_q < HIGH_ONE);
    end else begin
      high_s = (cyc_q < HIGH_ZERO);
    end
  end

  assign pix_ready  = !fifo_full_s;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty_s;
  assign sout       = sout_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  // FIFO write/read pointers and storage.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_q[i] <= 9'd0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q[FASIZE-1:0]] <= {pix_last, pix_color};
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Serializer FSM with registered line and status pulses.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      shift_q      <= 24'd0;
      last_q       <= 1'b0;
      bit_cnt_q    <= 5'd0;
      cyc_q        <= '0;
      lat_q        <= '0;
      sout_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      // The line follows the state one cycle later, hence the 2-cycle push-to-rise.
      sout_q       <= (state_q == ST_BIT) && high_s;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            shift_q   <= expand_rgb332(head_s[7:0]);
            last_q    <= head_s[8];
            bit_cnt_q <= 5'd23;
            cyc_q     <= '0;
            state_q   <= ST_BIT;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_BIT: begin
          if (cyc_q != CYC_LAST) begin
            cyc_q <= cyc_q + CYC_ONE;
          end else begin
            cyc_q <= '0;
            if (bit_cnt_q != 5'd0) begin
              shift_q   <= {shift_q[22:0], 1'b0};
              bit_cnt_q <= bit_cnt_q - 5'd1;
            end else if (last_q) begin
              lat_q   <= '0;
              state_q <= ST_LATCH;
            end else if (!fifo_empty_s) begin
              shift_q   <= expand_rgb332(head_s[7:0]);
              last_q    <= head_s[8];
              bit_cnt_q <= 5'd23;
            end else begin
              underrun_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
        end
        ST_LATCH: begin
          if (lat_q == LAT_LAST) begin
            lat_q        <= '0;
            frame_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            lat_q <= lat_q + LAT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
